// File: rtl/quad_encoder_ctrl_if.sv
// Quadrature encoder controller bus.
// Groups the encoder lines, decode enable, load/configuration values and the
// value/status outputs of quad_encoder_ctrl.
//   master : drives en, enc_a, enc_b, load, ini, min, max, step
//   slave  : the controller; drives data, step_pulse, dir, err
interface quad_encoder_ctrl_if #(
  parameter int WIDTH = 10
);
  logic             en;
  logic             enc_a;
  logic             enc_b;
  logic             load;
  logic [WIDTH-1:0] ini;
  logic [WIDTH-1:0] min;
  logic [WIDTH-1:0] max;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] data;
  logic             step_pulse;
  logic             dir;
  logic             err;

  modport master (
    output en, enc_a, enc_b, load, ini, min, max, step,
    input  data, step_pulse, dir, err
  );

  modport slave (
    input  en, enc_a, enc_b, load, ini, min, max, step,
    output data, step_pulse, dir, err
  );
endinterface

// File: rtl/quad_encoder_ctrl.sv
// Rotary encoder front end.
// Synchronises and debounces the raw A/B lines, decodes full Gray-code detent
// cycles into signed steps and keeps a bounded WIDTH-bit value with optional
// acceleration and saturate/wrap range handling.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : quad_encoder_ctrl_if.slave (en, enc_a, enc_b, load, ini, min, max,
//          step in; data, step_pulse, dir, err out)
//
// FSM states (ab = {debounced A, debounced B}):
//   state  | meaning
//   WAIT   | waiting for the detent (ab==11) before decoding
//   DET    | resting at detent
//   CW1    | ab==01, clockwise start
//   CW2    | ab==00, clockwise middle
//   CW3    | ab==10, clockwise last quarter; 11 commits +s
//   CCW1   | ab==10, counter-clockwise start
//   CCW2   | ab==00, counter-clockwise middle
//   CCW3   | ab==01, counter-clockwise last quarter; 11 commits -s
module quad_encoder_ctrl #(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter bit WRAP        = 1'b0,
  parameter int ACCEL_WIN   = 1000,
  parameter int ACCEL_SHIFT = 0
) (
  input  logic                clk,
  input  logic                rst,
  quad_encoder_ctrl_if.slave  bus
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int ACC_W = $clog2(ACCEL_WIN + 1);

  typedef enum logic [2:0] {
    S_WAIT, S_DET, S_CW1, S_CW2, S_CW3, S_CCW1, S_CCW2, S_CCW3
  } state_t;

  // synchroniser
  logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
  logic [1:0]             synced;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a_q <= '1;
      sync_b_q <= '1;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], bus.enc_a};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], bus.enc_b};
    end
  end

  assign synced = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

  // debounce, bit 1 = A, bit 0 = B
  logic [1:0]            deb_q, deb_d;
  logic [1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (synced[i] != deb_q[i]) begin
        if (db_cnt_q[i] == CNT_W'(DEBOUNCE - 1)) deb_d[i] = synced[i];
        else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // ab_prev_q lets the FSM see a same-cycle change of both debounced lines
  logic [1:0] ab_prev_q;
  logic       ab_jump;
  logic       en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q     <= 2'b11;
      db_cnt_q  <= '0;
      ab_prev_q <= 2'b11;
      en_q      <= 1'b0;
    end else begin
      deb_q     <= deb_d;
      db_cnt_q  <= db_cnt_d;
      ab_prev_q <= deb_q;
      en_q      <= bus.en;
    end
  end

  assign ab_jump = ((deb_q ^ ab_prev_q) == 2'b11);

  // FSM
  state_t state_q, state_d;
  logic   commit_inc, commit_dec, illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_WAIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    commit_inc = 1'b0;
    commit_dec = 1'b0;
    illegal    = 1'b0;
    if (bus.en) begin
      if (!en_q) begin
        // first enabled cycle: restart from WAIT so a stale phase never commits
        state_d = S_WAIT;
      end else if (ab_jump) begin
        state_d = S_WAIT;
        illegal = 1'b1;
      end else begin
        unique case (state_q)
          S_WAIT: if (deb_q == 2'b11) state_d = S_DET;
          S_DET: begin
            if (deb_q == 2'b01)      state_d = S_CW1;
            else if (deb_q == 2'b10) state_d = S_CCW1;
          end
          S_CW1: begin
            if (deb_q == 2'b00)      state_d = S_CW2;
            else if (deb_q == 2'b11) state_d = S_DET;
          end
          S_CW2: begin
            if (deb_q == 2'b10)      state_d = S_CW3;
            else if (deb_q == 2'b01) state_d = S_CW1;
          end
          S_CW3: begin
            if (deb_q == 2'b11) begin
              state_d    = S_DET;
              commit_inc = 1'b1;
            end else if (deb_q == 2'b00) state_d = S_CW2;
          end
          S_CCW1: begin
            if (deb_q == 2'b00)      state_d = S_CCW2;
            else if (deb_q == 2'b11) state_d = S_DET;
          end
          S_CCW2: begin
            if (deb_q == 2'b01)      state_d = S_CCW3;
            else if (deb_q == 2'b10) state_d = S_CCW1;
          end
          S_CCW3: begin
            if (deb_q == 2'b11) begin
              state_d    = S_DET;
              commit_dec = 1'b1;
            end else if (deb_q == 2'b00) state_d = S_CCW2;
          end
          default: state_d = S_WAIT;
        endcase
      end
    end
  end

  // value datapath, all arithmetic WIDTH+1 bits unsigned
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic             pulse_q, pulse_d;
  logic             err_q, err_d;
  logic             hist_q, hist_d;
  logic [ACC_W-1:0] acc_cnt_q, acc_cnt_d;

  logic             commit, accel;
  logic [WIDTH:0]   s_base, s_eff, sum, lo_lim, new_val;

  assign commit = commit_inc | commit_dec;
  assign accel  = (ACCEL_SHIFT != 0) && hist_q && (acc_cnt_q < ACC_W'(ACCEL_WIN))
                  && (commit_inc == dir_q);
  assign s_base = {1'b0, bus.step};
  assign s_eff  = accel ? (s_base << ACCEL_SHIFT) : s_base;
  assign sum    = {1'b0, data_q} + s_eff;
  assign lo_lim = {1'b0, bus.min} + s_eff;

  always_comb begin
    if (commit_inc) begin
      if (sum > {1'b0, bus.max}) new_val = WRAP ? {1'b0, bus.min} : {1'b0, bus.max};
      else                       new_val = sum;
    end else begin
      if ({1'b0, data_q} < lo_lim) new_val = WRAP ? {1'b0, bus.max} : {1'b0, bus.min};
      else                         new_val = {1'b0, data_q} - s_eff;
    end
  end

  always_comb begin
    data_d    = data_q;
    dir_d     = dir_q;
    pulse_d   = 1'b0;
    err_d     = err_q | illegal;
    hist_d    = hist_q;
    acc_cnt_d = (acc_cnt_q == ACC_W'(ACCEL_WIN)) ? acc_cnt_q : acc_cnt_q + 1'b1;
    if (bus.load) begin
      data_d    = bus.ini;
      err_d     = 1'b0;
      hist_d    = 1'b0;
      acc_cnt_d = '0;
    end else if (commit) begin
      pulse_d   = 1'b1;
      dir_d     = commit_inc;
      hist_d    = 1'b1;
      acc_cnt_d = '0;
      // an inverted range leaves the value alone but still reports the detent
      if (bus.min <= bus.max) data_d = new_val[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      dir_q     <= 1'b0;
      pulse_q   <= 1'b0;
      err_q     <= 1'b0;
      hist_q    <= 1'b0;
      acc_cnt_q <= '0;
    end else begin
      data_q    <= data_d;
      dir_q     <= dir_d;
      pulse_q   <= pulse_d;
      err_q     <= err_d;
      hist_q    <= hist_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  assign bus.data       = data_q;
  assign bus.dir        = dir_q;
  assign bus.step_pulse = pulse_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_quad_encoder_ctrl.sv
// Directed bench for quad_encoder_ctrl. Three instances share the encoder
// lines: u_a saturates, u_b wraps, u_c accelerates (ACCEL_SHIFT=2).
module tb_quad_encoder_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       enc_a = 1'b1;
  logic       enc_b = 1'b1;
  logic [2:0] load_v = '0;
  logic [9:0] ini_v  [3];
  logic [9:0] min_v  [3];
  logic [9:0] max_v  [3];
  logic [9:0] step_v [3];

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt_a = 0;
  int p0;

  always #5 clk = ~clk;

  quad_encoder_ctrl_if #(.WIDTH(10)) if_a ();
  quad_encoder_ctrl_if #(.WIDTH(10)) if_b ();
  quad_encoder_ctrl_if #(.WIDTH(10)) if_c ();

  assign if_a.en = en;  assign if_b.en = en;  assign if_c.en = en;
  assign if_a.enc_a = enc_a;  assign if_b.enc_a = enc_a;  assign if_c.enc_a = enc_a;
  assign if_a.enc_b = enc_b;  assign if_b.enc_b = enc_b;  assign if_c.enc_b = enc_b;
  assign if_a.load = load_v[0];  assign if_b.load = load_v[1];  assign if_c.load = load_v[2];
  assign if_a.ini = ini_v[0];    assign if_b.ini = ini_v[1];    assign if_c.ini = ini_v[2];
  assign if_a.min = min_v[0];    assign if_b.min = min_v[1];    assign if_c.min = min_v[2];
  assign if_a.max = max_v[0];    assign if_b.max = max_v[1];    assign if_c.max = max_v[2];
  assign if_a.step = step_v[0];  assign if_b.step = step_v[1];  assign if_c.step = step_v[2];

  quad_encoder_ctrl #(.WIDTH(10), .DEBOUNCE(4), .WRAP(1'b0), .ACCEL_SHIFT(0))
    u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  quad_encoder_ctrl #(.WIDTH(10), .DEBOUNCE(4), .WRAP(1'b1), .ACCEL_SHIFT(0))
    u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  quad_encoder_ctrl #(.WIDTH(10), .DEBOUNCE(4), .WRAP(1'b0), .ACCEL_WIN(1000), .ACCEL_SHIFT(2))
    u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  always @(posedge clk) if (if_a.step_pulse) pulse_cnt_a <= pulse_cnt_a + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_load(input int idx, input int ini, input int mn, input int mx, input int st);
    @(negedge clk);
    ini_v[idx]  = 10'(ini);
    min_v[idx]  = 10'(mn);
    max_v[idx]  = 10'(mx);
    step_v[idx] = 10'(st);
    load_v[idx] = 1'b1;
    @(negedge clk);
    load_v[idx] = 1'b0;
  endtask

  task automatic set_ab(input logic [1:0] ab, input int n);
    @(negedge clk);
    enc_a = ab[1];
    enc_b = ab[0];
    repeat (n) @(negedge clk);
  endtask

  task automatic cw();
    set_ab(2'b01, 20); set_ab(2'b00, 20); set_ab(2'b10, 20); set_ab(2'b11, 20);
  endtask

  task automatic ccw();
    set_ab(2'b10, 20); set_ab(2'b00, 20); set_ab(2'b01, 20); set_ab(2'b11, 20);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      ini_v[i] = '0; min_v[i] = '0; max_v[i] = '0; step_v[i] = '0;
    end
    repeat (4) @(negedge clk);
    check("rst_data",  32'(if_a.data), 0);
    check("rst_dir",   32'(if_a.dir), 0);
    check("rst_err",   32'(if_a.err), 0);
    check("rst_pulse", 32'(if_a.step_pulse), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // one clean CW detent, commit latency checked on u_a
    do_load(0, 500, 0, 1023, 1);
    do_load(1, 500, 0, 1023, 1);
    do_load(2, 500, 0, 1023, 1);
    set_ab(2'b01, 20); set_ab(2'b00, 20); set_ab(2'b10, 20);
    @(negedge clk);
    enc_a = 1'b1; enc_b = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("lat_pulse_early", 32'(if_a.step_pulse), 0);
    @(posedge clk);
    #1 check("lat_pulse_edge", 32'(if_a.step_pulse), 1);
    check("cw_data", 32'(if_a.data), 501);
    check("cw_dir", 32'(if_a.dir), 1);
    repeat (20) @(negedge clk);
    check("cw_data_wrapinst", 32'(if_b.data), 501);
    check("cw_first_not_accel", 32'(if_c.data), 501);

    // three CCW detents with step 10
    do_load(0, 500, 0, 1023, 10);
    p0 = pulse_cnt_a;
    ccw(); ccw(); ccw();
    check("ccw3_data", 32'(if_a.data), 470);
    check("ccw3_dir", 32'(if_a.dir), 0);
    check("ccw3_pulses", 32'(pulse_cnt_a - p0), 3);

    // saturate vs wrap at max, then wrap below min
    do_load(0, 500, 0, 505, 10);
    do_load(1, 500, 0, 505, 10);
    cw();
    check("sat_max", 32'(if_a.data), 505);
    check("wrap_max", 32'(if_b.data), 0);
    do_load(1, 3, 0, 1023, 10);
    ccw();
    check("wrap_min", 32'(if_b.data), 1023);
    check("sat_dec", 32'(if_a.data), 495);

    // glitches at rest, then half cycle with reversal
    do_load(0, 500, 0, 1023, 1);
    p0 = pulse_cnt_a;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      enc_a = 1'b0;
      repeat (2) @(negedge clk);
      enc_a = 1'b1;
      repeat (20) @(negedge clk);
    end
    check("glitch_data", 32'(if_a.data), 500);
    check("glitch_err", 32'(if_a.err), 0);
    set_ab(2'b01, 20); set_ab(2'b00, 20); set_ab(2'b01, 20); set_ab(2'b11, 20);
    check("reverse_data", 32'(if_a.data), 500);
    check("reverse_pulses", 32'(pulse_cnt_a - p0), 0);

    // disabled decode
    en = 1'b0;
    cw();
    check("en0_data", 32'(if_a.data), 500);
    en = 1'b1;
    repeat (20) @(negedge clk);
    cw();
    check("en1_data", 32'(if_a.data), 501);

    // illegal Gray jump 11->00
    set_ab(2'b00, 20);
    check("illegal_err", 32'(if_a.err), 1);
    set_ab(2'b11, 20);
    check("illegal_data", 32'(if_a.data), 501);
    do_load(0, 500, 0, 1023, 1);
    check("load_clr_err", 32'(if_a.err), 0);
    check("load_data", 32'(if_a.data), 500);

    // acceleration on u_c
    do_load(2, 500, 0, 1023, 1);
    cw();
    check("acc_first", 32'(if_c.data), 501);
    repeat (200) @(negedge clk);
    cw();
    check("acc_fast", 32'(if_c.data), 505);
    repeat (2000) @(negedge clk);
    cw();
    check("acc_slow", 32'(if_c.data), 506);

    // reset mid-rotation in CW2
    set_ab(2'b01, 20); set_ab(2'b00, 20);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrot_rst_data", 32'(if_c.data), 0);
    rst = 1'b0;
    set_ab(2'b10, 20); set_ab(2'b11, 20);
    check("midrot_no_commit", 32'(if_c.data), 0);
    cw();
    check("after_rst_cw", 32'(if_c.data), 1);
    check("after_rst_dir", 32'(if_c.dir), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_encoder_ctrl.md
Name: quad_encoder_ctrl

Overview:
- Parametrised rotary-encoder front end for the LogicSlice control path.
- Synchronises and debounces the two raw encoder lines, then decodes full Gray-code detent cycles into signed steps.
- Maintains a WIDTH-bit bounded value with per-detent step, optional acceleration, and saturate or wrap-around range handling.
- Feeds UI/parameter registers. It generalises the fixed 10-bit, saturate-only, undebounced encoder.

Parameters:
- WIDTH, 10: width of data, ini, min, max, step.
- SYNC_STAGES, 2: synchroniser flops per encoder line (>=2).
- DEBOUNCE, 4: consecutive stable cycles required before a line change is accepted (>=1).
- WRAP, 0: 0 = saturate at min/max; 1 = wrap max->min / min->max.
- ACCEL_WIN, 1000: maximum cycles between same-direction commits for acceleration to apply.
- ACCEL_SHIFT, 0: effective step = step << ACCEL_SHIFT when accelerated; 0 disables acceleration.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: decode enable.
- enc_a, input, 1: raw encoder line A (asynchronous).
- enc_b, input, 1: raw encoder line B (asynchronous).
- load, input, 1: single-cycle pulse; data <= ini.
- ini, input, WIDTH: load value.
- min, input, WIDTH: lower bound.
- max, input, WIDTH: upper bound.
- step, input, WIDTH: increment per detent.
- data, output, WIDTH: current value.
- step_pulse, output, 1: 1-cycle pulse on every committed detent.
- dir, output, 1: direction of the last commit (1 = increment); held between commits.
- err, output, 1: sticky illegal-transition flag; cleared by load or rst.

Behaviour:
- Reset (async, rst=1):
  - data=0, step_pulse=0, dir=0, err=0.
  - Synchronisers and debounced lines = 2'b11.
  - FSM = WAIT; debounce and acceleration counters = 0.
- Synchroniser: SYNC_STAGES flops on each line, reset to 1.
- Debounce, per line:
  - The counter increments while the synced value differs from the debounced value; it clears when they are equal.
  - The debounced value takes the synced value on the edge where the counter reaches DEBOUNCE-1.
  - The counter is then cleared.
- Line naming: ab denotes {debounced A, debounced B}. 11 is the detent.
- FSM states: WAIT, DET, CW1, CW2, CW3, CCW1, CCW2, CCW3. Transitions are evaluated every cycle while en=1.
  - WAIT: ab==11 -> DET; otherwise stay.
  - DET: 01 -> CW1; 10 -> CCW1.
  - CW1: 00 -> CW2; 11 -> DET (abort, no count).
  - CW2: 10 -> CW3; 01 -> CW1.
  - CW3: 11 -> DET with increment commit; 00 -> CW2.
  - CCW1: 00 -> CCW2; 11 -> DET (abort, no count).
  - CCW2: 01 -> CCW3; 10 -> CCW1.
  - CCW3: 11 -> DET with decrement commit; 00 -> CCW2.
  - Any change of both debounced bits in one cycle (an illegal Gray jump) -> err=1, state WAIT, no commit.
- Commit: data, dir and step_pulse all update on the same edge as the FSM transition to DET.
  - Latency from the synced input reaching 11 to the data update = DEBOUNCE+1 cycles.
- Effective step s:
  - s = step << ACCEL_SHIFT when the acceleration counter < ACCEL_WIN and this commit has the same direction as the previous one.
  - Otherwise s = step.
  - The acceleration counter clears on every commit and counts up (saturating at ACCEL_WIN) otherwise.
  - The first commit after reset or load is never accelerated.
  - The shifted value is truncated to WIDTH+1 bits.
- Arithmetic is done in WIDTH+1 bits, unsigned.
  - Increment, if data+s > max: WRAP=0 -> max; WRAP=1 -> min. Otherwise data+s.
  - Decrement, if data < min+s: WRAP=0 -> min; WRAP=1 -> max. Otherwise data-s.
  - step=0: commit still pulses step_pulse and updates dir; data is unchanged.
  - min>max: commits pulse step_pulse and update dir; data is unchanged.
- load:
  - data <= ini unclamped, err <= 0, acceleration history cleared.
  - load has priority over a commit in the same cycle; that commit is discarded, with no step_pulse.
  - load works regardless of en.
- en=0:
  - FSM frozen, no commits; synchroniser and debounce keep running.
  - When en rises, the FSM enters WAIT and must see 11 before decoding.
- Reset mid-rotation: the FSM goes to WAIT, so a partial cycle never commits.

Test Plan:
- WIDTH=10, DEBOUNCE=4, WRAP=0: load ini=500, step=1, min=0, max=1023. Drive one clean CW cycle (11->01->00->10->11), each phase held 20 cycles -> data=501, dir=1, one step_pulse, DEBOUNCE+1 cycles after synced 11.
- From data=500, apply 3 CCW cycles with step=10 -> data=470, dir=0, three step_pulses.
- Saturation and wrap: max=505, data=500, step=10, one CW cycle -> data=505 (WRAP=0); same case with WRAP=1 -> data=min=0. min=0, data=3, step=10, one CCW cycle with WRAP=1 -> data=1023.
- Glitch: 2-cycle pulses on A while resting at 11 -> no state change, data unchanged. Half cycle then reversal (11->01->00->01->11) -> no commit.
- Illegal jump: 11->00 stable with no intermediate state -> err=1, no commit. load then clears err.
- Acceleration with ACCEL_SHIFT=2, ACCEL_WIN=1000, step=1: two CW cycles 200 cycles apart -> +1 then +4. A third CW cycle 2000 cycles later -> +1. Asserting rst during CW2 -> data=0, and the next full cycle commits normally.
